// File: rtl/func_sweep_ctrl.sv
// Sweep sequencer for a function-approximation datapath: steps a signed input across a range,
// settles, samples the output against a reference and accumulates error statistics.
module func_sweep_ctrl #(
  parameter int IN_W   = 18,
  parameter int OUT_W  = 18,
  parameter int SETTLE = 16,
  parameter int ACC_W  = 48,
  parameter int CNT_W  = 16
) (
  input  logic                    emu_clk,
  input  logic                    emu_rst_n,
  input  logic                    start,
  input  logic signed [IN_W-1:0]  sweep_start,
  input  logic signed [IN_W-1:0]  sweep_stop,
  input  logic        [IN_W-2:0]  sweep_step,
  input  logic        [OUT_W-1:0] err_tol,
  output logic signed [IN_W-1:0]  func_in,
  input  logic signed [OUT_W-1:0] func_out,
  input  logic signed [OUT_W-1:0] expct,
  output logic                    busy,
  output logic                    done,
  output logic        [CNT_W-1:0] n_samp,
  output logic        [ACC_W-1:0] sum_err_sq,
  output logic        [OUT_W-1:0] max_abs_err,
  output logic                    acc_ovf,
  output logic                    pass
);

  localparam int SQ_W  = 2*OUT_W + 2;
  localparam int SUM_W = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;
  localparam int SC_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_STEP, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic signed [IN_W-1:0]   stop_q, stop_d;
  logic        [IN_W-2:0]   step_q, step_d;
  logic        [OUT_W-1:0]  tol_q, tol_d;
  logic signed [IN_W-1:0]   func_in_q, func_in_d;
  logic        [SC_W-1:0]   cnt_q, cnt_d;
  logic                     busy_q, busy_d;
  logic        [CNT_W-1:0]  n_samp_q, n_samp_d;
  logic        [ACC_W-1:0]  sum_q, sum_d;
  logic        [OUT_W-1:0]  max_q, max_d;
  logic                     ovf_q, ovf_d;
  logic                     pass_q, pass_d;

  logic signed [OUT_W:0]    diff;
  logic        [OUT_W:0]    abs_v;
  logic        [OUT_W-1:0]  abs_clip;
  logic        [SQ_W-1:0]   sq;
  logic        [SUM_W-1:0]  sum_ext;
  logic signed [IN_W:0]     nxt;
  logic                     stop_hit;

  always_comb begin
    state_d   = state_q;
    stop_d    = stop_q;
    step_d    = step_q;
    tol_d     = tol_q;
    func_in_d = func_in_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    n_samp_d  = n_samp_q;
    sum_d     = sum_q;
    max_d     = max_q;
    ovf_d     = ovf_q;
    pass_d    = pass_q;

    diff     = $signed({expct[OUT_W-1], expct}) - $signed({func_out[OUT_W-1], func_out});
    abs_v    = diff[OUT_W] ? -diff : diff;
    abs_clip = abs_v[OUT_W] ? '1 : abs_v[OUT_W-1:0];
    sq       = SQ_W'(abs_v) * SQ_W'(abs_v);
    sum_ext  = SUM_W'(sum_q) + SUM_W'(sq);
    nxt      = $signed({func_in_q[IN_W-1], func_in_q}) + $signed({2'b00, step_q});
    // Out of IN_W range shows up as the two top bits disagreeing.
    stop_hit = (nxt > $signed({stop_q[IN_W-1], stop_q})) || (nxt[IN_W] ^ nxt[IN_W-1]);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          stop_d   = sweep_stop;
          step_d   = sweep_step;
          tol_d    = err_tol;
          n_samp_d = '0;
          sum_d    = '0;
          max_d    = '0;
          ovf_d    = 1'b0;
          pass_d   = 1'b0;
          busy_d   = 1'b1;
          if (sweep_start <= sweep_stop) begin
            func_in_d = sweep_start;
            cnt_d     = SC_W'(SETTLE - 1);
            state_d   = S_SETTLE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_SAMPLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_SAMPLE: begin
        if (|sum_ext[SUM_W-1:ACC_W]) begin
          sum_d = '1;
          ovf_d = 1'b1;
        end else begin
          sum_d = sum_ext[ACC_W-1:0];
        end
        if (abs_clip > max_q) max_d = abs_clip;
        if (&n_samp_q) ovf_d    = 1'b1;
        else           n_samp_d = n_samp_q + 1'b1;
        state_d = S_STEP;
      end
      S_STEP: begin
        if (stop_hit) begin
          // Statistics are final here, so pass is already valid during the done pulse.
          pass_d  = (n_samp_q != '0) && (max_q <= tol_q) && !ovf_q;
          state_d = S_DONE;
        end else begin
          func_in_d = nxt[IN_W-1:0];
          cnt_d     = SC_W'(SETTLE - 1);
          state_d   = S_SETTLE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge emu_clk) begin
    if (!emu_rst_n) begin
      state_q   <= S_IDLE;
      stop_q    <= '0;
      step_q    <= '0;
      tol_q     <= '0;
      func_in_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      n_samp_q  <= '0;
      sum_q     <= '0;
      max_q     <= '0;
      ovf_q     <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      stop_q    <= stop_d;
      step_q    <= step_d;
      tol_q     <= tol_d;
      func_in_q <= func_in_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      n_samp_q  <= n_samp_d;
      sum_q     <= sum_d;
      max_q     <= max_d;
      ovf_q     <= ovf_d;
      pass_q    <= pass_d;
    end
  end

  assign func_in     = func_in_q;
  assign busy        = busy_q;
  assign done        = (state_q == S_DONE);
  assign n_samp      = n_samp_q;
  assign sum_err_sq  = sum_q;
  assign max_abs_err = max_q;
  assign acc_ovf     = ovf_q;
  assign pass        = pass_q;

endmodule

// File: tb/tb_func_sweep_ctrl.sv
// Bench for func_sweep_ctrl: two instances (48-bit and 20-bit accumulator) share stimulus and are
// checked against a point-list model of each sweep.
module tb_func_sweep_ctrl;

  localparam int IN_W = 18;
  localparam int OUT_W = 18;
  localparam int SET = 4;
  localparam int CNT_W = 16;
  localparam longint MAX48 = (64'sd1 <<< 48) - 1;
  localparam longint MAX20 = (64'sd1 <<< 20) - 1;

  logic emu_clk = 1'b0;
  logic emu_rst_n = 1'b0;
  logic start = 1'b0;
  logic signed [IN_W-1:0] sw_start = '0, sw_stop = '0;
  logic [IN_W-2:0] sw_step = '0;
  logic [OUT_W-1:0] tol = '0;
  int mode = 0, seed = 0;

  logic signed [IN_W-1:0] fin0, fin1;
  logic signed [OUT_W-1:0] fo0, ex0, fo1, ex1;
  logic busy0, busy1, done0, done1, ovf0, ovf1, pass0, pass1;
  logic [CNT_W-1:0] ns0, ns1;
  logic [47:0] sum0;
  logic [19:0] sum1;
  logic [OUT_W-1:0] mx0, mx1;

  int errors = 0, checks = 0;
  int exp_fin = 0;

  always #5 emu_clk = ~emu_clk;

  function automatic int wrap18(input int v);
    logic [17:0] t;
    t = v[17:0];
    return int'($signed(t));
  endfunction

  // Stimulus response: 0 exact, 1 extreme error, 2 constant +3 error, 3 pseudo-random error
  function automatic int calc_fo(input int p, input int md, input int sd);
    if (md == 1) return -131072;
    return wrap18(p * 5 + sd);
  endfunction

  function automatic int calc_ex(input int p, input int md, input int sd);
    int fo;
    fo = calc_fo(p, md, sd);
    case (md)
      1: return 131071;
      2: return wrap18(fo + 3);
      3: return wrap18(fo + ((p ^ sd) & 31) - 16);
      default: return fo;
    endcase
  endfunction

  assign fo0 = OUT_W'(calc_fo(int'(fin0), mode, seed));
  assign ex0 = OUT_W'(calc_ex(int'(fin0), mode, seed));
  assign fo1 = OUT_W'(calc_fo(int'(fin1), mode, seed));
  assign ex1 = OUT_W'(calc_ex(int'(fin1), mode, seed));

  func_sweep_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(SET), .ACC_W(48), .CNT_W(CNT_W)) u_dut (
    .emu_clk(emu_clk), .emu_rst_n(emu_rst_n), .start(start),
    .sweep_start(sw_start), .sweep_stop(sw_stop), .sweep_step(sw_step), .err_tol(tol),
    .func_in(fin0), .func_out(fo0), .expct(ex0),
    .busy(busy0), .done(done0), .n_samp(ns0), .sum_err_sq(sum0),
    .max_abs_err(mx0), .acc_ovf(ovf0), .pass(pass0));

  func_sweep_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(SET), .ACC_W(20), .CNT_W(CNT_W)) u_sat (
    .emu_clk(emu_clk), .emu_rst_n(emu_rst_n), .start(start),
    .sweep_start(sw_start), .sweep_stop(sw_stop), .sweep_step(sw_step), .err_tol(tol),
    .func_in(fin1), .func_out(fo1), .expct(ex1),
    .busy(busy1), .done(done1), .n_samp(ns1), .sum_err_sq(sum1),
    .max_abs_err(mx1), .acc_ovf(ovf1), .pass(pass1));

  task automatic chk_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk_eq({tag, "_fin"}, longint'(fin0), 0);
    chk_eq({tag, "_busy"}, longint'(busy0), 0);
    chk_eq({tag, "_done"}, longint'(done0 | done1), 0);
    chk_eq({tag, "_n"}, longint'(ns0) + longint'(ns1), 0);
    chk_eq({tag, "_sum"}, longint'(sum0) + longint'(sum1), 0);
    chk_eq({tag, "_max"}, longint'(mx0), 0);
    chk_eq({tag, "_flags"}, longint'({ovf0, ovf1, pass0, pass1}), 0);
  endtask

  task automatic run_sweep(input int s, input int e, input int st, input int tl,
                           input int md, input int sd, input bit spam);
    int p, npts, d, a, cyc, exp_cyc, mx;
    longint sq, s48, s20;
    bit o48, o20, p48, p20;
    npts = 0; s48 = 0; s20 = 0; mx = 0; o48 = 0; o20 = 0;
    p = s;
    while (p <= e && p <= 131071) begin
      d = calc_ex(p, md, sd) - calc_fo(p, md, sd);
      a = (d < 0) ? -d : d;
      sq = longint'(a) * longint'(a);
      s48 += sq; if (s48 > MAX48) begin s48 = MAX48; o48 = 1; end
      s20 += sq; if (s20 > MAX20) begin s20 = MAX20; o20 = 1; end
      if (((a > 262143) ? 262143 : a) > mx) mx = (a > 262143) ? 262143 : a;
      exp_fin = p;
      npts++;
      p += st;
    end
    p48 = (npts > 0) && (mx <= tl) && !o48;
    p20 = (npts > 0) && (mx <= tl) && !o20;
    exp_cyc = (npts == 0) ? 1 : npts * (SET + 2) + 1;

    @(negedge emu_clk);
    mode = md; seed = sd;
    sw_start = IN_W'(s); sw_stop = IN_W'(e); sw_step = (IN_W-1)'(st); tol = OUT_W'(tl);
    start = 1'b1;
    cyc = 0;
    while (cyc < 3000) begin
      @(negedge emu_clk);
      cyc++;
      start = 1'b0;
      if (cyc == 1) chk_eq("busy_after_start", longint'(busy0 & busy1), 1);
      if (done0) break;
      if (spam && (cyc % 7 == 3)) start = 1'b1;
    end
    chk_eq("done_cycle", cyc, exp_cyc);
    chk_eq("done_both", longint'(done1), 1);
    chk_eq("n_samp", longint'(ns0), npts);
    chk_eq("n_samp20", longint'(ns1), npts);
    chk_eq("sum_err_sq", longint'(sum0), s48);
    chk_eq("sum_err_sq20", longint'(sum1), s20);
    chk_eq("max_abs_err", longint'(mx0), mx);
    chk_eq("max_abs_err20", longint'(mx1), mx);
    chk_eq("acc_ovf", longint'(ovf0), longint'(o48));
    chk_eq("acc_ovf20", longint'(ovf1), longint'(o20));
    chk_eq("pass", longint'(pass0), longint'(p48));
    chk_eq("pass20", longint'(pass1), longint'(p20));
    chk_eq("func_in_last", longint'(fin0), exp_fin);
    chk_eq("func_in_last20", longint'(fin1), exp_fin);
    if (spam) start = 1'b1;
    @(negedge emu_clk);
    start = 1'b0;
    chk_eq("idle_busy", longint'(busy0 | busy1), 0);
    chk_eq("idle_done", longint'(done0 | done1), 0);
    chk_eq("idle_pass_hold", longint'(pass0), longint'(p48));
    chk_eq("idle_n_hold", longint'(ns0), npts);
  endtask

  initial begin
    int hit;
    repeat (3) @(negedge emu_clk);
    chk_idle_zero("reset");
    emu_rst_n = 1'b1;
    @(negedge emu_clk);

    run_sweep(-4, 4, 2, 0, 0, 7, 0);
    run_sweep(-4, 4, 2, 2, 2, 11, 0);
    run_sweep(5, 5, 1, 0, 0, 1, 0);
    run_sweep(6, 5, 1, 0, 0, 1, 0);
    run_sweep(131060, 131071, 5, 4, 3, 99, 0);
    run_sweep(131000, 131071, 131071, 20, 3, 5, 0);
    run_sweep(-2, 2, 1, 262143, 1, 0, 0);

    // Reset in the middle of the third point's settle window.
    @(negedge emu_clk);
    mode = 3; seed = 1234;
    sw_start = -18'sd50; sw_stop = 18'sd50; sw_step = 17'd3; tol = 18'd100;
    start = 1'b1;
    @(negedge emu_clk);
    start = 1'b0;
    repeat (14) @(negedge emu_clk);
    chk_eq("pre_reset_n", longint'(ns0), 2);
    emu_rst_n = 1'b0;
    @(negedge emu_clk);
    emu_rst_n = 1'b1;
    chk_idle_zero("midreset");
    exp_fin = 0;
    hit = 0;
    repeat (40) begin
      @(negedge emu_clk);
      if (done0 || done1 || busy0) hit = 1;
    end
    chk_eq("no_done_after_reset", hit, 0);

    run_sweep(-10, 20, 3, 8, 3, 77, 1);

    for (int i = 0; i < 12; i++) begin
      int s, e;
      s = int'($urandom_range(400)) - 200;
      e = s + int'($urandom_range(70)) - 10;
      run_sweep(s, e, int'($urandom_range(20, 1)), int'($urandom_range(20)), 3,
                int'($urandom_range(65535)), bit'($urandom_range(1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
